// File: rtl/risc_v_mike_muldiv_pkg.sv
// Shared types and constants for the risc_v_mike M-extension multiply/divide unit.
package risc_v_mike_muldiv_pkg;

  localparam int DATA_32_W  = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [6:0] OPCODE_R_TYPE = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef logic [REG_ADDR_W-1:0] t_register_addr;

  // Encoded exactly as funct3 so the decoder can pass it straight through.
  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } t_muldiv_op;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } t_muldiv_state;

  typedef enum logic [5:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_ILLEGAL
  } t_instr_nmemonic;

  // True when an R-type instruction belongs to the M extension.
  function automatic logic is_muldiv(input logic [6:0] opcode, input logic [6:0] funct7);
    return (opcode == OPCODE_R_TYPE) && (funct7 == FUNCT7_MULDIV);
  endfunction

endpackage

// File: rtl/risc_v_mike_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2 shift-add multiply,
// restoring divide, one bit per cycle, with optional early-out for the
// divide-by-zero and signed-overflow corner cases.
//
//   state | meaning
//   IDLE  | waiting for start (also holds a pending early-out result for one cycle)
//   CALC  | iterating, count runs XLEN-1 down to 0
//   DONE  | result valid this cycle; a new start is accepted without a bubble
module risc_v_mike_muldiv
  import risc_v_mike_muldiv_pkg::*;
#(
  parameter int XLEN      = DATA_32_W,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  t_muldiv_op      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  t_register_addr  rd_addr,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output t_register_addr  done_rd_addr
);

  localparam int              CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] SMIN  = {1'b1, {(XLEN-1){1'b0}}};

  t_muldiv_state     r_state;
  logic [CNT_W-1:0]  r_count;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opnd;
  t_muldiv_op        r_op;
  logic              r_neg;
  logic              r_div_zero;
  logic              r_early;
  t_register_addr    r_rd;
  logic              r_done;
  logic [XLEN-1:0]   r_result;
  t_register_addr    r_done_rd;

  logic              w_accept;
  logic              w_rs1_signed, w_rs2_signed;
  logic              w_s1, w_s2, w_neg;
  logic [XLEN-1:0]   w_abs1, w_abs2;
  logic              w_rs2_zero, w_ovf, w_special;
  logic [XLEN-1:0]   w_special_res;

  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [XLEN:0]     w_div_shift, w_div_diff;
  logic              w_div_ok;
  logic [XLEN-1:0]   w_div_rem;
  logic [2*XLEN-1:0] w_div_next;
  logic [2*XLEN-1:0] w_acc_next;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_lo, w_hi, w_quo, w_rem, w_final;

  // A start during CALC is ignored and flush always beats start.
  assign w_accept = start && !flush && (r_state != CALC);

  // Operand conditioning at acceptance: magnitudes, result sign and corner cases.
  always_comb begin
    w_rs1_signed  = (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
    w_rs2_signed  = (op == MULH) || (op == DIV) || (op == REM);
    w_s1          = w_rs1_signed & rs1[XLEN-1];
    w_s2          = w_rs2_signed & rs2[XLEN-1];
    w_abs1        = w_s1 ? (~rs1 + 1'b1) : rs1;
    w_abs2        = w_s2 ? (~rs2 + 1'b1) : rs2;
    w_neg         = ((op == REM) || (op == REMU)) ? w_s1 : (w_s1 ^ w_s2);
    w_rs2_zero    = (rs2 == '0);
    w_ovf         = ((op == DIV) || (op == REM)) && (rs1 == SMIN) && (rs2 == '1);
    w_special     = op[2] && (w_rs2_zero || w_ovf);
    w_special_res = '0;
    if (op[1]) w_special_res = w_rs2_zero ? rs1 : '0;
    else       w_special_res = w_rs2_zero ? '1 : rs1;
  end

  // One iteration of multiply or divide plus the sign-corrected final result.
  // Accumulator holds {hi, lo}: product-high/multiplier for MUL*, remainder/quotient for DIV*.
  always_comb begin
    w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_mul_next  = {w_mul_sum, r_acc[XLEN-1:1]};
    w_div_shift = r_acc[2*XLEN-1:XLEN-1];
    w_div_diff  = w_div_shift - {1'b0, r_opnd};
    w_div_ok    = ~w_div_diff[XLEN];
    w_div_rem   = w_div_ok ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
    w_div_next  = {w_div_rem, r_acc[XLEN-2:0], w_div_ok};
    w_acc_next  = r_op[2] ? w_div_next : w_mul_next;
    w_lo        = w_acc_next[XLEN-1:0];
    w_hi        = w_acc_next[2*XLEN-1:XLEN];
    w_prod      = r_neg ? (~w_acc_next + 1'b1) : w_acc_next;
    // A zero divisor would otherwise pick up the dividend's sign.
    w_quo       = r_div_zero ? '1 : (r_neg ? (~w_lo + 1'b1) : w_lo);
    w_rem       = r_neg ? (~w_hi + 1'b1) : w_hi;
    case (r_op)
      MUL:                 w_final = w_prod[XLEN-1:0];
      MULH, MULHSU, MULHU: w_final = w_prod[2*XLEN-1:XLEN];
      DIV, DIVU:           w_final = w_quo;
      default:             w_final = w_rem;
    endcase
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_acc      <= '0;
      r_opnd     <= '0;
      r_op       <= MUL;
      r_neg      <= 1'b0;
      r_div_zero <= 1'b0;
      r_early    <= 1'b0;
      r_rd       <= '0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_done_rd  <= '0;
    end else begin
      r_done <= 1'b0;
      if (flush) begin
        r_state <= IDLE;
        r_early <= 1'b0;
      end else begin
        case (r_state)
          IDLE, DONE: begin
            // Early-out result was parked in the accumulator on the accepting edge.
            if (r_early) begin
              r_early   <= 1'b0;
              r_result  <= r_acc[XLEN-1:0];
              r_done    <= 1'b1;
              r_done_rd <= r_rd;
              r_state   <= DONE;
            end else begin
              r_state <= IDLE;
            end
            if (w_accept) begin
              r_op       <= op;
              r_rd       <= rd_addr;
              r_neg      <= w_neg;
              r_div_zero <= op[2] && w_rs2_zero;
              r_opnd     <= w_abs2;
              if (EARLY_OUT && w_special) begin
                r_early <= 1'b1;
                r_acc   <= {{XLEN{1'b0}}, w_special_res};
                r_state <= IDLE;
              end else begin
                r_acc   <= {{XLEN{1'b0}}, w_abs1};
                r_count <= CNT_W'(XLEN-1);
                r_state <= CALC;
              end
            end
          end
          CALC: begin
            r_acc   <= w_acc_next;
            r_count <= r_count - 1'b1;
            if (r_count == '0) begin
              r_result  <= w_final;
              r_done    <= 1'b1;
              r_done_rd <= r_rd;
              r_state   <= DONE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign busy         = (r_state == CALC);
  assign done         = r_done;
  assign result       = r_result;
  assign done_rd_addr = r_done_rd;

endmodule

// File: tb/tb_risc_v_mike_muldiv.sv
// Scoreboard bench: one EARLY_OUT=1 and one EARLY_OUT=0 instance share stimulus;
// expected result, tag and latency are queued at issue and checked at done.
module tb_risc_v_mike_muldiv;
  import risc_v_mike_muldiv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, start, flush;
  t_muldiv_op     op;
  logic [31:0]    rs1, rs2;
  t_register_addr rd_addr;
  logic           busy_eo, done_eo, busy_fl, done_fl;
  logic [31:0]    res_eo, res_fl;
  t_register_addr drd_eo, drd_fl;

  risc_v_mike_muldiv #(.XLEN(32), .EARLY_OUT(1'b1)) u_dut_eo (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .rd_addr(rd_addr), .flush(flush), .busy(busy_eo), .done(done_eo),
    .result(res_eo), .done_rd_addr(drd_eo));

  risc_v_mike_muldiv #(.XLEN(32), .EARLY_OUT(1'b0)) u_dut_fl (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .rd_addr(rd_addr), .flush(flush), .busy(busy_fl), .done(done_fl),
    .result(res_fl), .done_rd_addr(drd_fl));

  typedef struct {
    logic [31:0]    res;
    t_register_addr tag;
    int             lat;
    int             acc;
  } exp_t;

  exp_t        q_eo[$], q_fl[$];
  exp_t        m_eo, m_fl;
  int          n_checks = 0, n_errors = 0;
  int          cyc = 0;
  logic [31:0] last_exp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input t_muldiv_op o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub, p;
    logic [63:0] up, pv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    case (o)
      MUL:    begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
      MULH:   begin p = sa * sb; pv = p; return pv[63:32]; end
      MULHSU: begin p = sa * ub; pv = p; return pv[63:32]; end
      MULHU:  begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      DIV:    begin
        if (b == 0) return 32'hFFFFFFFF;
        p = sa / sb; return p[31:0];
      end
      DIVU:   return (b == 0) ? 32'hFFFFFFFF : a / b;
      REM:    begin
        if (b == 0) return a;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input t_muldiv_op o, input logic [31:0] a, input logic [31:0] b);
    return o[2] && ((b == 0) || (((o == DIV) || (o == REM)) && (a == 32'h80000000) && (b == 32'hFFFFFFFF)));
  endfunction

  // Result monitors (sampled on the falling edge).
  always @(negedge clk) begin
    if (done_eo) begin
      if (q_eo.size() == 0) chk("eo_spurious_done", {31'b0, done_eo}, 32'd0);
      else begin
        m_eo = q_eo.pop_front();
        chk("eo_result",  res_eo, m_eo.res);
        chk("eo_tag",     {27'b0, drd_eo}, {27'b0, m_eo.tag});
        chk("eo_latency", cyc - m_eo.acc, m_eo.lat);
        chk("eo_busy_at_done", {31'b0, busy_eo}, 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (done_fl) begin
      if (q_fl.size() == 0) chk("fl_spurious_done", {31'b0, done_fl}, 32'd0);
      else begin
        m_fl = q_fl.pop_front();
        chk("fl_result",  res_fl, m_fl.res);
        chk("fl_tag",     {27'b0, drd_fl}, {27'b0, m_fl.tag});
        chk("fl_latency", cyc - m_fl.acc, m_fl.lat);
        chk("fl_busy_at_done", {31'b0, busy_fl}, 32'd0);
      end
    end
  end

  // Drive one request for one cycle; called and returns at a falling edge.
  task automatic issue(input t_muldiv_op o, input logic [31:0] a, input logic [31:0] b,
                       input t_register_addr tag, input bit expect_done);
    exp_t e;
    op = o; rs1 = a; rs2 = b; rd_addr = tag; start = 1'b1;
    if (expect_done) begin
      e.res = model(o, a, b);
      e.tag = tag;
      e.acc = cyc + 1;
      e.lat = is_special(o, a, b) ? 1 : 32;
      q_eo.push_back(e);
      e.lat = 32;
      q_fl.push_back(e);
      last_exp = e.res;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (q_eo.size() + q_fl.size()) != 0; i++) @(negedge clk);
    chk("drain_timeout", 32'(q_eo.size() + q_fl.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic chk_idle_outputs(input string tag, input logic [31:0] exp_res);
    chk({tag, "_busy_eo"}, {31'b0, busy_eo}, 32'd0);
    chk({tag, "_busy_fl"}, {31'b0, busy_fl}, 32'd0);
    chk({tag, "_res_eo"},  res_eo, exp_res);
    chk({tag, "_res_fl"},  res_fl, exp_res);
  endtask

  t_muldiv_op  t_op[14];
  logic [31:0] t_a[14], t_b[14];

  initial begin
    t_op[0]  = MUL;    t_a[0]  = 32'd7;        t_b[0]  = 32'hFFFFFFFD;
    t_op[1]  = MULH;   t_a[1]  = 32'hFFFFFFFF; t_b[1]  = 32'hFFFFFFFF;
    t_op[2]  = MULHU;  t_a[2]  = 32'hFFFFFFFF; t_b[2]  = 32'hFFFFFFFF;
    t_op[3]  = MULHSU; t_a[3]  = 32'hFFFFFFFF; t_b[3]  = 32'd2;
    t_op[4]  = DIV;    t_a[4]  = 32'hFFFFFFEC; t_b[4]  = 32'd3;
    t_op[5]  = REM;    t_a[5]  = 32'hFFFFFFEC; t_b[5]  = 32'd3;
    t_op[6]  = DIVU;   t_a[6]  = 32'd100;      t_b[6]  = 32'd7;
    t_op[7]  = REMU;   t_a[7]  = 32'd100;      t_b[7]  = 32'd7;
    t_op[8]  = DIVU;   t_a[8]  = 32'd5;        t_b[8]  = 32'd0;
    t_op[9]  = REM;    t_a[9]  = 32'd5;        t_b[9]  = 32'd0;
    t_op[10] = DIV;    t_a[10] = 32'h80000000; t_b[10] = 32'hFFFFFFFF;
    t_op[11] = REM;    t_a[11] = 32'h80000000; t_b[11] = 32'hFFFFFFFF;
    t_op[12] = DIV;    t_a[12] = 32'hFFFFFFFB; t_b[12] = 32'd0;
    t_op[13] = REM;    t_a[13] = 32'hFFFFFFFB; t_b[13] = 32'd0;

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = MUL; rs1 = '0; rs2 = '0; rd_addr = '0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset", 32'd0);
    chk("reset_done_eo", {31'b0, done_eo}, 32'd0);
    chk("reset_tag_eo",  {27'b0, drd_eo}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      issue(t_op[i], t_a[i], t_b[i], t_register_addr'(i + 1), 1'b1);
      drain();
    end

    for (int i = 0; i < 6; i++) begin
      issue(t_muldiv_op'($urandom_range(0, 7)), $urandom, $urandom, t_register_addr'($urandom_range(1, 31)), 1'b1);
      drain();
    end

    // Back-to-back: second start lands in the DONE cycle of the first.
    issue(DIVU, 32'd1000, 32'd3, 5'd20, 1'b1);
    for (int i = 0; i < 40 && !done_fl; i++) @(negedge clk);
    issue(MUL, 32'h00012345, 32'h00000100, 5'd21, 1'b1);
    drain();

    // Flush in the middle of a divide: no done, busy drops, result held.
    issue(DIV, 32'd12345, 32'd17, 5'd22, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk_idle_outputs("flush", last_exp);
    repeat (40) @(negedge clk);
    chk_idle_outputs("flush_after", last_exp);

    // start together with flush is dropped.
    flush = 1'b1;
    issue(DIVU, 32'd9, 32'd0, 5'd23, 1'b0);
    flush = 1'b0;
    chk_idle_outputs("start_flush", last_exp);
    repeat (40) @(negedge clk);

    // Reset while calculating: everything cleared, no done.
    issue(MULHU, 32'hDEADBEEF, 32'h12345678, 5'd24, 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_idle_outputs("mid_reset", 32'd0);
    chk("mid_reset_tag_fl", {27'b0, drd_fl}, 32'd0);
    repeat (40) @(negedge clk);

    issue(REMU, 32'd1000, 32'd33, 5'd25, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
